// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode constants and memory-op decode shared by issue logic
package isa_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef logic [1:0] slot_valid_t;

  function automatic bit is_mem_op(input logic [6:0] inst_opc);
    return (inst_opc == OPC_LOAD) || (inst_opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/issue_pair_buffer.sv
// rtl/issue_pair_buffer.sv - 2-in/2-out instruction FIFO steering memory ops to the LSU pipe
module issue_pair_buffer
  import isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  slot_valid_t       in_valid,
  input  logic [XLEN-1:0]   in_inst0,
  input  logic [XLEN-1:0]   in_inst1,
  output logic              in_ready,
  output logic [XLEN-1:0]   out_inst0,
  output logic [XLEN-1:0]   out_inst1,
  output slot_valid_t       out_valid,
  output logic              out_swap,
  input  logic              issue_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] entries [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;

  logic [1:0]      push_n;
  logic [1:0]      pop_n;
  logic            mem0;
  logic            mem1;

  assign out_inst0 = entries[rd_ptr];
  assign out_inst1 = entries[rd_ptr + AW'(1)];

  assign mem0 = is_mem_op(out_inst0[6:0]);
  assign mem1 = is_mem_op(out_inst1[6:0]);

  // Pipe 0 has no LSU: a memory op in slot0 forces the swap, and two memory ops issue singly.
  always_comb begin
    out_valid = 2'b00;
    out_swap  = 1'b0;
    if (count == '0) begin
      out_valid = 2'b00;
    end else if (count == (AW+1)'(1)) begin
      out_valid = 2'b01;
      out_swap  = mem0;
    end else begin
      out_valid = (mem0 && mem1) ? 2'b01 : 2'b11;
      out_swap  = mem0;
    end
  end

  // Accept is judged on the registered count only, so it never waits on issue_ready.
  assign in_ready = (count <= (AW+1)'(DEPTH - 2));

  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    if (in_ready) begin
      push_n = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
    end
    if (issue_ready) begin
      pop_n = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_n);
      wr_ptr <= wr_ptr + AW'(push_n);
      count  <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && in_ready) begin
      if (in_valid[0]) begin
        entries[wr_ptr] <= in_inst0;
      end
      if (in_valid[1]) begin
        entries[wr_ptr + AW'(1)] <= in_inst1;
      end
    end
  end

  a_in_valid_legal: assert property (@(posedge clk) disable iff (!rst_n) in_valid != 2'b10);
  a_count_bound:    assert property (@(posedge clk) disable iff (!rst_n) count <= (AW+1)'(DEPTH));
  a_out_valid_ord:  assert property (@(posedge clk) disable iff (!rst_n) !(out_valid[1] && !out_valid[0]));

endmodule
